// File: rtl/alu_pkg.sv
// alu_pkg -- shared ALU definitions for the issue controller slice.
//   ALU_Sel function codes as seen by the downstream ALU, plus the
//   default operand width and register-address width.
package alu_pkg;

  localparam int ALU_DATA_W = 32;
  localparam int ALU_REG_AW = 3;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_NOR  = 3'b101,
    ALU_RSV6 = 3'b110,  // ALU returns 0; passed through unchanged
    ALU_RSV7 = 3'b111
  } alu_sel_e;

endpackage

// File: rtl/alu_regfile.sv
// alu_regfile -- 2**REG_AW x DATA_W architectural register file.
//   Two async read ports (rs1/rs2), one async debug read port and one
//   synchronous write port. Register 0 is hardwired to zero: reads
//   return 0 and writes to it are dropped.
// Ports:
//   clk, rst            clock, synchronous active-high reset (clears all)
//   we/waddr/wdata      write port
//   raddr_a/rdata_a     read port A
//   raddr_b/rdata_b     read port B
//   dbg_addr/dbg_data   debug read port
module alu_regfile
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int REG_AW = ALU_REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int NREG = 1 << REG_AW;

  logic [NREG-1:0][DATA_W-1:0] regs;

  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  // r0 decoded explicitly so the zero register never depends on storage
  assign rdata_a  = (raddr_a  == '0) ? '0 : regs[raddr_a];
  assign rdata_b  = (raddr_b  == '0) ? '0 : regs[raddr_b];
  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl -- two-stage issue/writeback controller around an
//   external combinational ALU.
//   EX : registered alu_a/alu_b/alu_sel drive the ALU; ex_rd/ex_valid
//        track the op currently being computed.
//   WB : registered result stream (wb_valid/wb_rd/wb_data) with
//        valid/ready backpressure; the register file is written as the
//        op moves EX->WB.
//   A source that matches the op in EX takes alu_out directly, so
//   back-to-back dependent ops issue without bubbles.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   op_valid/op_ready             micro-op handshake
//   op_sel/op_rd/op_rs1/op_rs2    function code and register operands
//   op_imm_en/op_imm              immediate replaces source B
//   alu_a/alu_b/alu_sel           registered drive to the ALU
//   alu_out/alu_zero              combinational ALU result and Zero
//   wb_valid/wb_ready/wb_rd/wb_data  result stream
//   zero_flag                     Zero of the last result moved to WB
//   dbg_addr/dbg_data             async register-file peek
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int REG_AW = ALU_REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [2:0]        op_sel,
  input  logic [REG_AW-1:0] op_rd,
  input  logic [REG_AW-1:0] op_rs1,
  input  logic [REG_AW-1:0] op_rs2,
  input  logic              op_imm_en,
  input  logic [DATA_W-1:0] op_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [REG_AW-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              zero_flag,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic              ex_valid;
  logic [REG_AW-1:0] ex_rd;
  logic              adv;      // WB can take a new result this edge
  logic              ex_xfer;  // EX -> WB transfer this edge
  logic              accept;   // new op enters EX this edge
  logic [DATA_W-1:0] rf_a, rf_b;
  logic [DATA_W-1:0] src_a, src_b;

  assign adv      = !wb_valid || wb_ready;
  assign ex_xfer  = ex_valid && adv;
  assign op_ready = !rst && (!ex_valid || adv);
  assign accept   = op_valid && op_ready;

  alu_regfile #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_rf (
    .clk      (clk),
    .rst      (rst),
    .we       (ex_xfer),
    .waddr    (ex_rd),
    .wdata    (alu_out),
    .raddr_a  (op_rs1),
    .rdata_a  (rf_a),
    .raddr_b  (op_rs2),
    .rdata_b  (rf_b),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // Source resolution. The op in EX has not reached the register file
  // yet, so its result is taken from alu_out. Whether or not it moves
  // to WB on this edge, alu_out is the value it will write. Anything
  // older has already been written to the register file.
  always_comb begin
    src_a = rf_a;
    if (op_rs1 == '0)
      src_a = '0;
    else if (ex_valid && ex_rd == op_rs1)
      src_a = alu_out;

    src_b = rf_b;
    if (op_rs2 == '0)
      src_b = '0;
    else if (ex_valid && ex_rd == op_rs2)
      src_b = alu_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid  <= 1'b0;
      ex_rd     <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      zero_flag <= 1'b0;
    end else begin
      // EX stage: the operand registers only load on accept, so they
      // (and therefore alu_out) hold steady through a WB stall.
      if (accept) begin
        alu_sel  <= op_sel;
        alu_a    <= src_a;
        alu_b    <= op_imm_en ? op_imm : src_b;
        ex_rd    <= op_rd;
        ex_valid <= 1'b1;
      end else if (ex_xfer) begin
        ex_valid <= 1'b0;
      end

      // WB stage: result and Zero captured as the op leaves EX.
      if (ex_xfer) begin
        wb_valid  <= 1'b1;
        wb_rd     <= ex_rd;
        wb_data   <= alu_out;
        zero_flag <= alu_zero;
      end else if (wb_valid && wb_ready) begin
        wb_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

  localparam int DW   = 32;
  localparam int AW   = 3;
  localparam int NREG = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          op_valid;
  logic          op_ready;
  logic [2:0]    op_sel;
  logic [AW-1:0] op_rd, op_rs1, op_rs2;
  logic          op_imm_en;
  logic [DW-1:0] op_imm;
  logic [DW-1:0] alu_a, alu_b, alu_out;
  logic [2:0]    alu_sel;
  logic          alu_zero;
  logic          wb_valid, wb_ready;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          zero_flag;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_data;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DATA_W(DW), .REG_AW(AW)) dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_sel(op_sel), .op_rd(op_rd), .op_rs1(op_rs1), .op_rs2(op_rs2),
    .op_imm_en(op_imm_en), .op_imm(op_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .zero_flag(zero_flag), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Function table of the downstream ALU
  function automatic logic [DW-1:0] alu_f(logic [2:0] s, logic [DW-1:0] a, logic [DW-1:0] b);
    case (s)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~(a | b);
      default: return '0;
    endcase
  endfunction

  // stand-in for the external combinational ALU
  always_comb begin
    alu_out  = alu_f(alu_sel, alu_a, alu_b);
    alu_zero = (alu_out == '0);
  end

  // ---------------- reference model ----------------
  // Ops execute in program order against an architectural register
  // array; each accepted op queues its expected writeback. At most two
  // ops can be outstanding, and an op is visible on WB from the edge
  // after its accept once everything older has been delivered.
  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
    logic          zero;
    logic [DW-1:0] a, b;
    logic [2:0]    sel;
    int            acc_edge;
  } wb_exp_t;

  wb_exp_t       q[$];
  logic [DW-1:0] arch[NREG];
  int            edge_cnt = 0;
  logic          last_acc = 1'b0;
  logic          just_acc = 1'b0;
  wb_exp_t       last_op;
  logic          stall_chk = 1'b0;
  logic [DW-1:0] st_a, st_b;
  logic [2:0]    st_sel;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h @%0t", tag, act, exp, $time);
    end
  endtask

  // One clock: check outputs against the model just before the edge,
  // then advance the model with what the edge does. Entered and left
  // at the falling edge; inputs are changed between calls.
  task automatic tick();
    logic acc, dlv, exp_v;
    #1;
    if (stall_chk) begin
      chk("stall_alu_a", alu_a, st_a);
      chk("stall_alu_b", alu_b, st_b);
      chk("stall_alu_sel", alu_sel, st_sel);
    end
    if (just_acc) begin
      chk("ex_alu_a", alu_a, last_op.a);
      chk("ex_alu_b", alu_b, last_op.b);
      chk("ex_alu_sel", alu_sel, last_op.sel);
    end
    chk("op_ready", op_ready, !rst && (q.size() < 2 || wb_ready));
    exp_v = (q.size() > 0) && (q[0].acc_edge < edge_cnt);
    chk("wb_valid", wb_valid, exp_v);
    if (exp_v && wb_valid) begin
      chk("wb_rd", wb_rd, q[0].rd);
      chk("wb_data", wb_data, q[0].data);
      chk("zero_flag", zero_flag, q[0].zero);
    end
    stall_chk = !rst && q.size() == 2 && !wb_ready;
    st_a = alu_a; st_b = alu_b; st_sel = alu_sel;
    acc = op_valid && op_ready;
    dlv = wb_valid && wb_ready;
    @(posedge clk);
    edge_cnt++;
    last_acc = 1'b0;
    just_acc = 1'b0;
    if (rst) begin
      q.delete();
      foreach (arch[i]) arch[i] = '0;
      stall_chk = 1'b0;
    end else begin
      if (dlv && q.size() > 0) void'(q.pop_front());
      if (acc) begin
        wb_exp_t e;
        e.a   = (op_rs1 == 0) ? '0 : arch[op_rs1];
        e.b   = op_imm_en ? op_imm : ((op_rs2 == 0) ? '0 : arch[op_rs2]);
        e.sel = op_sel;
        e.rd  = op_rd;
        e.data = alu_f(op_sel, e.a, e.b);
        e.zero = (e.data == '0);
        e.acc_edge = edge_cnt;
        if (op_rd != 0) arch[op_rd] = e.data;
        q.push_back(e);
        last_op  = e;
        last_acc = 1'b1;
        just_acc = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic set_op(input logic [2:0] s, input int rd, input int rs1, input int rs2,
                        input logic ie, input logic [DW-1:0] imm);
    op_sel = s; op_rd = AW'(rd); op_rs1 = AW'(rs1); op_rs2 = AW'(rs2);
    op_imm_en = ie; op_imm = imm;
  endtask

  // Offer one op and hold it until accepted (bounded).
  task automatic send_op(input logic [2:0] s, input int rd, input int rs1, input int rs2,
                         input logic ie, input logic [DW-1:0] imm);
    set_op(s, rd, rs1, rs2, ie, imm);
    op_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (last_acc) break;
    end
    chk("send_accepted", last_acc, 1'b1);
  endtask

  task automatic drain();
    op_valid = 1'b0;
    wb_ready = 1'b1;
    for (int i = 0; i < 10 && q.size() > 0; i++) tick();
    tick();
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic check_regs();
    for (int r = 0; r < NREG; r++) begin
      dbg_addr = AW'(r);
      #1;
      chk("dbg_reg", dbg_data, arch[r]);
    end
    @(negedge clk);
  endtask

  task automatic peek(input string tag, input int r, input logic [DW-1:0] exp);
    dbg_addr = AW'(r);
    #1;
    chk(tag, dbg_data, exp);
    @(negedge clk);
  endtask

  int acc_cnt;

  initial begin
    rst = 1'b1; op_valid = 1'b0; wb_ready = 1'b1; dbg_addr = '0;
    set_op(3'd0, 0, 0, 0, 1'b0, '0);
    foreach (arch[i]) arch[i] = '0;

    // reset: 3 cycles, op_ready low throughout
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_sel", alu_sel, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_zero_flag", zero_flag, 0);
    check_regs();
    tick();

    // immediate chain, back-to-back, r3 via forwarding
    wb_ready = 1'b1;
    send_op(3'd0, 1, 0, 0, 1'b1, 32'd5);
    send_op(3'd0, 2, 0, 0, 1'b1, 32'd7);
    send_op(3'd1, 3, 1, 2, 1'b0, 32'd0);
    drain();
    peek("chain_r1", 1, 32'd5);
    peek("chain_r2", 2, 32'd7);
    peek("chain_r3", 3, 32'hFFFF_FFFE);

    // forward with wrap to zero
    send_op(3'd0, 1, 0, 0, 1'b1, 32'hFFFF_FFFF);
    send_op(3'd0, 1, 1, 0, 1'b1, 32'd1);
    drain();
    chk("wrap_zero_flag", zero_flag, 1'b1);
    peek("wrap_r1", 1, 32'd0);

    // backpressure: wb_ready low 4 cycles, 3 ops offered
    wb_ready = 1'b0;
    acc_cnt = 0;
    op_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_op(3'(acc_cnt), 4 + acc_cnt, 3, 2, 1'b0, '0);
      tick();
      if (last_acc) acc_cnt++;
    end
    chk("bp_accepted", acc_cnt, 2);
    wb_ready = 1'b1;
    set_op(3'(acc_cnt), 4 + acc_cnt, 3, 2, 1'b0, '0);
    for (int i = 0; i < 5 && acc_cnt < 3; i++) begin
      tick();
      if (last_acc) acc_cnt++;
    end
    chk("bp_third", acc_cnt, 3);
    drain();
    check_regs();

    // write to r0: result streamed, register stays 0
    send_op(3'd4, 0, 0, 0, 1'b1, 32'hA5);
    op_valid = 1'b0;
    tick();
    chk("r0_wb_data", wb_data, 32'hA5);
    drain();
    peek("r0_dbg", 0, 32'd0);

    // mid-op reset: op accepted, reset next cycle
    send_op(3'd0, 6, 0, 0, 1'b1, 32'd9);
    op_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    peek("midrst_r6", 6, 32'd0);
    check_regs();

    // randomized traffic
    for (int it = 0; it < 1500; it++) begin
      rst       = ($urandom_range(0, 199) == 0);
      op_valid  = ($urandom_range(0, 9) < 7);
      wb_ready  = ($urandom_range(0, 3) != 0);
      op_sel    = 3'($urandom_range(0, 7));
      op_rd     = AW'($urandom);
      op_rs1    = AW'($urandom);
      op_rs2    = AW'($urandom);
      op_imm_en = $urandom_range(0, 1) == 1;
      op_imm    = ($urandom_range(0, 1) == 1) ? DW'($urandom_range(0, 3)) : DW'($urandom);
      tick();
      if (it % 250 == 249) begin
        rst = 1'b0;
        drain();
        check_regs();
      end
    end
    rst = 1'b0;
    drain();
    check_regs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
